// File: rtl/rgb_fade_pwm_if.sv
// Configuration request channel for rgb_fade_pwm: one request per cycle, no backpressure.
interface rgb_fade_pwm_if #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CW-1:0]    cfg_chan;
    logic [1:0]       cfg_mode;
    logic [WIDTH-1:0] cfg_target;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_chan, cfg_mode, cfg_target,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_mode, cfg_target,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/rgb_fade_pwm.sv
// Multi-channel LED PWM driver with per-channel hold / fade / breathe duty engine.
//
// state   | meaning
// HOLD    | duty is static, set directly by config
// FADE    | duty steps by 1 per tick toward tgt, then returns to HOLD
// BREATHE | duty sweeps 0..tgt and back, holding two ticks at each end
module rgb_fade_pwm #(
    parameter int CHANNELS   = 3,
    parameter int WIDTH      = 8,
    parameter int PRESCALE   = 262144,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    rgb_fade_pwm_if.slave             cfg,
    output logic [CHANNELS-1:0]       led_out,
    output logic [CHANNELS*WIDTH-1:0] duty_out,
    output logic [CHANNELS-1:0]       busy
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] CFG_HOLD    = 2'b00;
    localparam logic [1:0] CFG_FADE    = 2'b01;
    localparam logic [1:0] CFG_BREATHE = 2'b10;

    typedef enum logic [1:0] {HOLD, FADE, BREATHE} mode_t;

    logic [WIDTH-1:0] cnt;
    logic [PW-1:0]    pre;
    logic [WIDTH-1:0] duty   [CHANNELS];
    logic [WIDTH-1:0] shadow [CHANNELS];
    logic [WIDTH-1:0] tgt    [CHANNELS];
    mode_t            mode   [CHANNELS];
    logic             dir_up [CHANNELS];

    logic tick;
    logic accept;
    logic chan_ok;

    assign cfg.cfg_ready = ~rst;
    assign accept        = cfg.cfg_valid & cfg.cfg_ready;
    assign chan_ok       = 32'(cfg.cfg_chan) < CHANNELS;
    assign tick          = (pre == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            pre         <= '0;
            cfg.cfg_err <= 1'b0;
            led_out     <= {CHANNELS{ACTIVE_LOW}};
            for (int c = 0; c < CHANNELS; c++) begin
                duty[c]   <= '0;
                shadow[c] <= '0;
                tgt[c]    <= '0;
                mode[c]   <= HOLD;
                dir_up[c] <= 1'b1;
            end
        end else begin
            cnt         <= cnt + WIDTH'(1);
            pre         <= tick ? '0 : pre + PW'(1);
            cfg.cfg_err <= accept & ~chan_ok;
            for (int c = 0; c < CHANNELS; c++) begin
                // Shadow copy at the last count keeps each PWM period glitch-free.
                if (cnt == '1)
                    shadow[c] <= duty[c];
                led_out[c] <= (cnt < shadow[c]) ^ ACTIVE_LOW;

                if (accept && chan_ok && cfg.cfg_chan == CW'(c)) begin
                    case (cfg.cfg_mode)
                        CFG_HOLD: begin
                            duty[c] <= cfg.cfg_target;
                            mode[c] <= HOLD;
                        end
                        CFG_FADE: begin
                            tgt[c]  <= cfg.cfg_target;
                            mode[c] <= (duty[c] == cfg.cfg_target) ? HOLD : FADE;
                        end
                        CFG_BREATHE: begin
                            tgt[c]    <= cfg.cfg_target;
                            mode[c]   <= BREATHE;
                            dir_up[c] <= 1'b1;
                        end
                        default: begin
                            duty[c] <= '0;
                            mode[c] <= HOLD;
                        end
                    endcase
                end else if (tick) begin
                    case (mode[c])
                        FADE: begin
                            if (duty[c] < tgt[c]) begin
                                duty[c] <= duty[c] + WIDTH'(1);
                                if (tgt[c] - duty[c] == WIDTH'(1))
                                    mode[c] <= HOLD;
                            end else if (duty[c] > tgt[c]) begin
                                duty[c] <= duty[c] - WIDTH'(1);
                                if (duty[c] - tgt[c] == WIDTH'(1))
                                    mode[c] <= HOLD;
                            end else begin
                                mode[c] <= HOLD;
                            end
                        end
                        BREATHE: begin
                            if (dir_up[c]) begin
                                if (duty[c] < tgt[c])
                                    duty[c] <= duty[c] + WIDTH'(1);
                                else
                                    dir_up[c] <= 1'b0;
                            end else begin
                                if (duty[c] != '0)
                                    duty[c] <= duty[c] - WIDTH'(1);
                                else
                                    dir_up[c] <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        duty_out = '0;
        busy     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            duty_out[c*WIDTH +: WIDTH] = duty[c];
            busy[c]                    = (mode[c] != HOLD);
        end
    end
endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Directed and randomized checks of rgb_fade_pwm against a tick-rule duty model.
module tb_rgb_fade_pwm;
    localparam int CH = 3;
    localparam int W  = 8;
    localparam int PS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] led_out;
    logic [CH*W-1:0] duty_out;
    logic [CH-1:0] busy;

    rgb_fade_pwm_if #(.CHANNELS(CH), .WIDTH(W)) cfg ();

    rgb_fade_pwm #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(PS), .ACTIVE_LOW(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg      (cfg.slave),
        .led_out  (led_out),
        .duty_out (duty_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: duty values and modes (0 hold, 1 fade, 2 breathe).
    int m_duty [CH];
    int m_tgt  [CH];
    int m_mode [CH];
    bit m_up   [CH];
    int m_cyc;
    bit m_tick;
    bit m_err;

    int breathe_seq [9] = '{1, 2, 3, 3, 2, 1, 0, 0, 1};
    int fade_down   [3] = '{4, 3, 2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_duty();
        logic [31:0] v = '0;
        for (int c = 0; c < CH; c++) v |= 32'(m_duty[c] & 255) << (8 * c);
        return v;
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] v = '0;
        for (int c = 0; c < CH; c++) v[c] = (m_mode[c] != 0);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_duty[c] = 0; m_tgt[c] = 0; m_mode[c] = 0; m_up[c] = 1'b1;
        end
        m_cyc = 0;
        m_err = 1'b0;
    endtask

    task automatic clock(input bit v, input int ch, input int md, input int tg);
        bit tk;
        cfg.cfg_valid  = v;
        cfg.cfg_chan   = ch[1:0];
        cfg.cfg_mode   = md[1:0];
        cfg.cfg_target = tg[7:0];
        tk = (m_cyc % PS) == PS - 1;
        for (int c = 0; c < CH; c++) begin
            if (v && ch == c) begin
                case (md)
                    0: begin m_duty[c] = tg; m_mode[c] = 0; end
                    1: begin m_tgt[c] = tg; m_mode[c] = (m_duty[c] == tg) ? 0 : 1; end
                    2: begin m_tgt[c] = tg; m_mode[c] = 2; m_up[c] = 1'b1; end
                    default: begin m_duty[c] = 0; m_mode[c] = 0; end
                endcase
            end else if (tk && m_mode[c] == 1) begin
                m_duty[c] += (m_tgt[c] > m_duty[c]) ? 1 : -1;
                if (m_duty[c] == m_tgt[c]) m_mode[c] = 0;
            end else if (tk && m_mode[c] == 2) begin
                if (m_up[c]) begin
                    if (m_duty[c] < m_tgt[c]) m_duty[c]++;
                    else m_up[c] = 1'b0;
                end else begin
                    if (m_duty[c] > 0) m_duty[c]--;
                    else m_up[c] = 1'b1;
                end
            end
        end
        m_err  = v && (ch >= CH);
        m_tick = tk;
        @(posedge clk);
        #1;
        m_cyc++;
        cfg.cfg_valid = 1'b0;
        chk("duty_out", duty_out, exp_duty());
        chk("busy", 32'(busy), exp_busy());
        chk("cfg_err", 32'(cfg.cfg_err), 32'(m_err));
        chk("cfg_ready", 32'(cfg.cfg_ready), 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clock(1'b0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        rst            = 1'b1;
        cfg.cfg_valid  = 1'b1;
        cfg.cfg_chan   = 2'd0;
        cfg.cfg_mode   = 2'b00;
        cfg.cfg_target = 8'd99;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_reset();
            chk("rst_led", 32'(led_out), 32'h7);
            chk("rst_duty", duty_out, 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_err", 32'(cfg.cfg_err), 0);
            chk("rst_ready", 32'(cfg.cfg_ready), 0);
        end
        rst           = 1'b0;
        cfg.cfg_valid = 1'b0;
        #1;
        chk("ready_after_rst", 32'(cfg.cfg_ready), 1);
    endtask

    // Advance at least one cycle, up to the edge that reloads the shadow duty.
    task automatic sync_period();
        do clock(1'b0, 0, 0, 0); while (m_cyc % 256 != 0);
    endtask

    // Count on-cycles (pin low) over one full period; optionally reconfigure mid-period.
    task automatic count_low(input int ch, input int exp, input string tag,
                             input int chg_at, input int chg_val);
        int n = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == chg_at) clock(1'b1, ch, 0, chg_val);
            else clock(1'b0, 0, 0, 0);
            if (led_out[ch] == 1'b0) n++;
        end
        chk(tag, n, exp);
    endtask

    initial begin
        int k;
        int nt;
        int budget;
        logic [31:0] saved;

        cfg.cfg_valid  = 1'b0;
        cfg.cfg_chan   = '0;
        cfg.cfg_mode   = '0;
        cfg.cfg_target = '0;
        model_reset();
        #1;
        do_reset(3);

        // HOLD and pin duty
        clock(1'b1, 0, 0, 64);
        chk("hold64_duty", 32'(duty_out[7:0]), 64);
        sync_period();
        count_low(0, 64, "led_low_64", -1, 0);
        clock(1'b1, 0, 0, 0);
        sync_period();
        count_low(0, 0, "led_low_0", -1, 0);
        clock(1'b1, 0, 0, 255);
        sync_period();
        count_low(0, 255, "led_low_255", -1, 0);
        clock(1'b1, 0, 0, 64);
        sync_period();
        count_low(0, 64, "led_glitch_free", 100, 200);
        count_low(0, 200, "led_low_200", -1, 0);

        // FADE ch1 0 -> 5, then down to 2
        clock(1'b1, 1, 1, 5);
        nt = 0;
        budget = 40;
        while (busy[1] && budget > 0) begin
            clock(1'b0, 0, 0, 0);
            if (m_tick) nt++;
            budget--;
        end
        chk("fade_up_done", 32'(budget > 0), 1);
        chk("fade_up_ticks", nt, 5);
        chk("fade_up_duty", 32'(duty_out[15:8]), 5);
        clock(1'b1, 1, 1, 2);
        k = 0;
        budget = 40;
        while (k < 3 && budget > 0) begin
            clock(1'b0, 0, 0, 0);
            if (m_tick) begin
                chk("fade_down_step", 32'(duty_out[15:8]), fade_down[k]);
                k++;
            end
            budget--;
        end
        chk("fade_down_steps", k, 3);
        chk("fade_down_idle", 32'(busy[1]), 0);

        // BREATHE ch2 ceiling 3
        clock(1'b1, 2, 2, 3);
        k = 0;
        budget = 80;
        while (k < 9 && budget > 0) begin
            clock(1'b0, 0, 0, 0);
            if (m_tick) begin
                chk("breathe_step", 32'(duty_out[23:16]), breathe_seq[k]);
                chk("breathe_busy", 32'(busy[2]), 1);
                k++;
            end
            budget--;
        end
        chk("breathe_steps", k, 9);
        clock(1'b1, 2, 3, 0);
        chk("off_duty", 32'(duty_out[23:16]), 0);
        chk("off_busy", 32'(busy[2]), 0);

        // Invalid channel
        saved = duty_out;
        clock(1'b1, 3, 0, 77);
        chk("bad_chan_err", 32'(cfg.cfg_err), 1);
        chk("bad_chan_nochg", duty_out, saved);
        clock(1'b0, 0, 0, 0);
        chk("bad_chan_pulse", 32'(cfg.cfg_err), 0);

        // HOLD landing on a tick while ch1 is fading
        clock(1'b1, 1, 1, 200);
        while (m_cyc % PS != PS - 1) clock(1'b0, 0, 0, 0);
        clock(1'b1, 1, 0, 10);
        chk("tick_collision_duty", 32'(duty_out[15:8]), 10);
        chk("tick_collision_busy", 32'(busy[1]), 0);

        // Reset mid-breathe
        clock(1'b1, 2, 2, 6);
        idle(30);
        do_reset(1);
        idle(30);
        chk("post_rst_duty", duty_out, 0);
        chk("post_rst_busy", 32'(busy), 0);

        // Randomized config traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0)
                clock(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12))
                                                  : int'($urandom_range(0, 255)));
            else
                clock(1'b0, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
